// File: rtl/multicycle_control_unit_pkg.sv
// Purpose: shared encodings for the multi-cycle RISC-V control unit (states, ALU ops, opcodes, mux selects).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_LUI       = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    // ALU operation codes; OR and ORI share one code, LUI passes operand B through.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b1000;
    localparam logic [3:0] ALU_ORI = 4'b1001;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Datapath control word (everything except the ALU op and debug state).
    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Purpose: control-unit <-> datapath bundle: IR fields and status in, enables/selects/ALU op out.
// Latency: n/a (wires only).
// Backpressure: mem_ready_i stretches memory states; no other flow control.
// Ports: master = control unit (drives *_o), slave = datapath (drives *_i).
interface multicycle_control_unit_if #(parameter int STATE_W = 4);
    logic [6:0]         opcode_i;
    logic [2:0]         funct3_i;
    logic [6:0]         funct7_i;
    logic               zero_i;
    logic               mem_ready_i;
    logic               PC_Write_o;
    logic               PC_Src_o;
    logic               IR_Write_o;
    logic               Mem_Read_o;
    logic               Mem_Write_o;
    logic               Reg_Write_o;
    logic [1:0]         ALU_Src_A_o;
    logic [1:0]         ALU_Src_B_o;
    logic [3:0]         ALU_Operation_o;
    logic [1:0]         Result_Src_o;
    logic               halted_o;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  opcode_i, funct3_i, funct7_i, zero_i, mem_ready_i,
        output PC_Write_o, PC_Src_o, IR_Write_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
               ALU_Src_A_o, ALU_Src_B_o, ALU_Operation_o, Result_Src_o, halted_o, state_o
    );

    modport slave (
        output opcode_i, funct3_i, funct7_i, zero_i, mem_ready_i,
        input  PC_Write_o, PC_Src_o, IR_Write_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
               ALU_Src_A_o, ALU_Src_B_o, ALU_Operation_o, Result_Src_o, halted_o, state_o
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Purpose: maps {state, funct3, funct7} to the ALU op code and flags unsupported R/I encodings.
// Latency: combinational.
// Backpressure: none.
// Ports: state/funct3/funct7 in; alu_op, illegal out.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (state)
            S_EXEC_R: begin
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_BASE)     alu_op = ALU_ADD;
                        else if (funct7 == F7_ALT) alu_op = ALU_SUB;
                        else                       illegal = 1'b1;
                    end
                    F3_AND:  alu_op = ALU_AND;
                    F3_OR:   alu_op = ALU_ORI;
                    default: illegal = 1'b1;
                endcase
            end
            S_EXEC_I: begin
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_OR:   alu_op = ALU_ORI;
                    F3_AND:  alu_op = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            S_LUI:    alu_op = ALU_LUI;
            S_BRANCH: alu_op = ALU_SUB;
            default:  alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: main control FSM of the multi-cycle RISC-V datapath; Moore outputs plus ALU op issue.
// Latency: R/I/LUI/sw 4 cycles, lw 5, beq/jal 3, plus one cycle per memory wait.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold until mem_ready_i; HALT holds until reset.
// Ports: clk, reset (sync, active-low), bus (master modport of multicycle_control_unit_if).
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic [3:0] alu_op;
    logic       alu_illegal;

    alu_decoder u_alu_decoder (
        .state   (state),
        .funct3  (bus.funct3_i),
        .funct7  (bus.funct7_i),
        .alu_op  (alu_op),
        .illegal (alu_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                // PC/IR only load on the cycle the instruction word actually arrives.
                ctrl.pc_write  = bus.mem_ready_i;
                ctrl.ir_write  = bus.mem_ready_i;
                if (bus.mem_ready_i) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute oldPC+imm so BRANCH/JAL find their target in ALUOut.
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                case (bus.opcode_i)
                    OPC_LOAD, OPC_STORE: state_nxt = S_MEM_ADDR;
                    OPC_R:               state_nxt = S_EXEC_R;
                    OPC_I:               state_nxt = S_EXEC_I;
                    OPC_BRANCH:          state_nxt = S_BRANCH;
                    OPC_JAL:             state_nxt = S_JAL;
                    OPC_LUI:             state_nxt = S_LUI;
                    default:             state_nxt = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                state_nxt = (bus.opcode_i == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                if (bus.mem_ready_i) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                state_nxt = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                if (bus.mem_ready_i) state_nxt = S_FETCH;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                state_nxt = alu_illegal ? S_HALT : S_ALU_WB;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                state_nxt = alu_illegal ? S_HALT : S_ALU_WB;
            end
            S_LUI: begin
                ctrl.alu_src_a = SRC_A_ZERO;
                ctrl.alu_src_b = SRC_B_IMM;
                state_nxt = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.pc_src    = 1'b1;
                ctrl.pc_write  = bus.zero_i;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                // rd <= oldPC+4 from the live ALU result while PC takes the target in ALUOut.
                ctrl.alu_src_a  = SRC_A_OLDPC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.reg_write  = 1'b1;
                ctrl.pc_src     = 1'b1;
                ctrl.pc_write   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
                state_nxt = S_HALT;
            end
            default: state_nxt = S_HALT;
        endcase
    end

    // Outputs are forced to zero while reset is held so an aborted instruction cannot write.
    assign ctrl_out = reset ? ctrl : '0;

    assign bus.PC_Write_o      = ctrl_out.pc_write;
    assign bus.PC_Src_o        = ctrl_out.pc_src;
    assign bus.IR_Write_o      = ctrl_out.ir_write;
    assign bus.Mem_Read_o      = ctrl_out.mem_read;
    assign bus.Mem_Write_o     = ctrl_out.mem_write;
    assign bus.Reg_Write_o     = ctrl_out.reg_write;
    assign bus.ALU_Src_A_o     = ctrl_out.alu_src_a;
    assign bus.ALU_Src_B_o     = ctrl_out.alu_src_b;
    assign bus.Result_Src_o    = ctrl_out.result_src;
    assign bus.halted_o        = ctrl_out.halted;
    assign bus.ALU_Operation_o = reset ? alu_op : 4'b0000;
    assign bus.state_o         = reset ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Purpose: self-checking bench for multicycle_control_unit: latency table, per-cycle trace model, corner sequences.
// Latency: n/a.
// Backpressure: drives mem_ready_i low at random to exercise memory wait states.
module tb_multicycle_control_unit;
    import riscv_ctrl_pkg::*;

    typedef struct packed {
        logic       pcw, pcs, irw, mr, mw, rw;
        logic [1:0] a, b;
        logic [3:0] op;
        logic [1:0] rs;
        logic       hlt;
        logic [3:0] st;
    } out_t;

    typedef struct {
        out_t  o;
        bit    mem;   // phase waits for mem_ready_i
        bit    br;    // PC write follows zero_i
        string nm;
    } exp_t;

    typedef exp_t exp_q_t[$];

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         len;
        int         halt;
        int         rw;
        string      nm;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    multicycle_control_unit_if #(.STATE_W(4)) bus ();

    multicycle_control_unit #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t got_out();
        return out_t'({bus.PC_Write_o, bus.PC_Src_o, bus.IR_Write_o, bus.Mem_Read_o,
                       bus.Mem_Write_o, bus.Reg_Write_o, bus.ALU_Src_A_o, bus.ALU_Src_B_o,
                       bus.ALU_Operation_o, bus.Result_Src_o, bus.halted_o, bus.state_o});
    endfunction

    task automatic chk(input out_t e, input string nm);
        out_t g;
        g = got_out();
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %06h required %06h (st got %0d req %0d)", nm, g, e, g.st, e.st);
        end
    endtask

    task automatic chk_int(input int g, input int e, input string nm);
        n_vec++;
        if (g != e) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, g, e);
        end
    endtask

    // One clock cycle: inputs already driven, outputs sampled at the falling edge.
    task automatic cyc(input out_t e, input string nm);
        @(negedge clk);
        chk(e, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.zero_i = 1'b1;
        cyc('0, "reset_outputs_zero");
        reset = 1'b1;
    endtask

    function automatic exp_t ph(input state_t s, input string nm);
        exp_t e;
        e.o = '0;
        e.o.st = s;
        e.mem = 1'b0;
        e.br = 1'b0;
        e.nm = nm;
        return e;
    endfunction

    // Reference model: the per-cycle output trace of one instruction, derived from the instruction class.
    function automatic exp_q_t build(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        exp_q_t q;
        exp_t e;
        e = ph(S_FETCH, "fetch"); e.o.mr = 1; e.o.b = SRC_B_FOUR; e.o.pcw = 1; e.o.irw = 1; e.mem = 1; q.push_back(e);
        e = ph(S_DECODE, "decode"); e.o.a = SRC_A_OLDPC; e.o.b = SRC_B_IMM; q.push_back(e);
        if (opc == OPC_LOAD || opc == OPC_STORE) begin
            e = ph(S_MEM_ADDR, "mem_addr"); e.o.a = SRC_A_RS1; e.o.b = SRC_B_IMM; q.push_back(e);
            if (opc == OPC_LOAD) begin
                e = ph(S_MEM_READ, "mem_read"); e.o.mr = 1; e.mem = 1; q.push_back(e);
                e = ph(S_MEM_WB, "mem_wb"); e.o.rw = 1; e.o.rs = RES_MEM; q.push_back(e);
            end else begin
                e = ph(S_MEM_WRITE, "mem_write"); e.o.mw = 1; e.mem = 1; q.push_back(e);
            end
        end else if (opc == OPC_R || opc == OPC_I || opc == OPC_LUI) begin
            if (opc == OPC_LUI) begin
                e = ph(S_LUI, "lui"); e.o.a = SRC_A_ZERO; e.o.b = SRC_B_IMM; e.o.op = ALU_LUI;
            end else begin
                e = ph(opc == OPC_R ? S_EXEC_R : S_EXEC_I, "exec");
                e.o.a = SRC_A_RS1;
                e.o.b = (opc == OPC_R) ? SRC_B_RS2 : SRC_B_IMM;
                e.o.op = (f3 == 3'b111) ? ALU_AND : (f3 == 3'b110) ? ALU_ORI :
                         (opc == OPC_R && f7 == 7'h20) ? ALU_SUB : ALU_ADD;
            end
            q.push_back(e);
            e = ph(S_ALU_WB, "alu_wb"); e.o.rw = 1; q.push_back(e);
        end else if (opc == OPC_BRANCH) begin
            e = ph(S_BRANCH, "branch"); e.o.a = SRC_A_RS1; e.o.op = ALU_SUB; e.o.pcs = 1; e.br = 1; q.push_back(e);
        end else if (opc == OPC_JAL) begin
            e = ph(S_JAL, "jal"); e.o.a = SRC_A_OLDPC; e.o.b = SRC_B_FOUR; e.o.rs = RES_ALU;
            e.o.rw = 1; e.o.pcs = 1; e.o.pcw = 1; q.push_back(e);
        end else begin
            e = ph(S_HALT, "halt"); e.o.hlt = 1; q.push_back(e);
        end
        return q;
    endfunction

    // fz/fw < 0 select random zero_i / wait counts.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input int fz, input int fw, output bit halted);
        exp_q_t q;
        exp_t e;
        out_t w;
        int n;
        q = build(opc, f3, f7);
        bus.opcode_i = opc;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
        halted = 1'b0;
        foreach (q[i]) begin
            e = q[i];
            if (e.mem) begin
                n = (fw >= 0) ? fw : int'($urandom_range(0, 2));
                for (int k = 0; k < n; k++) begin
                    bus.mem_ready_i = 1'b0;
                    bus.zero_i = 1'($urandom);
                    w = e.o; w.pcw = 1'b0; w.irw = 1'b0;
                    cyc(w, {e.nm, "_wait"});
                end
                bus.mem_ready_i = 1'b1;
            end else begin
                bus.mem_ready_i = 1'($urandom);
            end
            bus.zero_i = (fz >= 0) ? fz[0] : 1'($urandom);
            if (e.br) e.o.pcw = bus.zero_i;
            cyc(e.o, e.nm);
            if (e.o.hlt) halted = 1'b1;
        end
    endtask

    vec_t  tbl[15];
    bit    h;
    int    len, rw, wb_at, mr_cnt, waits, rs_wb;
    bit    done, in_halt;
    exp_q_t sq;
    exp_t  fe;

    initial begin
        bus.opcode_i = '0; bus.funct3_i = '0; bus.funct7_i = '0;
        bus.zero_i = 1'b0; bus.mem_ready_i = 1'b0;

        tbl[0]  = '{OPC_R,      3'b000, 7'h00, 4, 0, 1, "add"};
        tbl[1]  = '{OPC_R,      3'b000, 7'h20, 4, 0, 1, "sub"};
        tbl[2]  = '{OPC_R,      3'b111, 7'h00, 4, 0, 1, "and"};
        tbl[3]  = '{OPC_R,      3'b110, 7'h00, 4, 0, 1, "or"};
        tbl[4]  = '{OPC_R,      3'b001, 7'h00, 3, 1, 0, "r_bad_f3"};
        tbl[5]  = '{OPC_I,      3'b000, 7'h00, 4, 0, 1, "addi"};
        tbl[6]  = '{OPC_I,      3'b110, 7'h00, 4, 0, 1, "ori"};
        tbl[7]  = '{OPC_I,      3'b111, 7'h00, 4, 0, 1, "andi"};
        tbl[8]  = '{OPC_I,      3'b010, 7'h00, 3, 1, 0, "i_bad_f3"};
        tbl[9]  = '{OPC_LOAD,   3'b010, 7'h00, 5, 0, 1, "lw"};
        tbl[10] = '{OPC_STORE,  3'b010, 7'h00, 4, 0, 0, "sw"};
        tbl[11] = '{OPC_BRANCH, 3'b000, 7'h00, 3, 0, 0, "beq"};
        tbl[12] = '{OPC_JAL,    3'b000, 7'h00, 3, 0, 1, "jal"};
        tbl[13] = '{OPC_LUI,    3'b000, 7'h00, 4, 0, 1, "lui"};
        tbl[14] = '{7'h7f,      3'b000, 7'h00, 2, 1, 0, "illegal_op"};

        repeat (2) @(posedge clk);
        #1;

        // Latency / halt / register-write count per instruction, memory always ready.
        foreach (tbl[i]) begin
            reset_dut();
            bus.opcode_i = tbl[i].opc; bus.funct3_i = tbl[i].f3; bus.funct7_i = tbl[i].f7;
            bus.mem_ready_i = 1'b1; bus.zero_i = 1'b1;
            len = 0; rw = 0; done = 0; in_halt = 0;
            for (int c = 0; c < 20 && !done; c++) begin
                @(negedge clk);
                if (c > 0 && (bus.state_o == S_FETCH || bus.state_o == S_HALT)) begin
                    done = 1;
                    in_halt = (bus.state_o == S_HALT);
                end else begin
                    len++;
                    rw += int'(bus.Reg_Write_o);
                end
                @(posedge clk);
                #1;
            end
            if (!done) begin
                n_vec++; n_bad++;
                $display("FAIL %s_timeout: got no return within 20 cycles required %0d", tbl[i].nm, tbl[i].len);
            end
            chk_int(len, tbl[i].len, {tbl[i].nm, "_latency"});
            chk_int(int'(in_halt), tbl[i].halt, {tbl[i].nm, "_halt"});
            chk_int(rw, tbl[i].rw, {tbl[i].nm, "_regwrite_cycles"});
        end

        // add x3,x1,x2 then lui / ori, full per-cycle trace.
        reset_dut();
        run_instr(OPC_R, 3'b000, 7'h00, -1, 0, h);
        run_instr(OPC_LUI, 3'b000, 7'h00, -1, 0, h);
        run_instr(OPC_I, 3'b110, 7'h00, -1, 0, h);

        // beq taken then not taken.
        run_instr(OPC_BRANCH, 3'b000, 7'h00, 1, 0, h);
        run_instr(OPC_BRANCH, 3'b000, 7'h00, 0, 0, h);

        // lw with three wait cycles in MEM_READ.
        reset_dut();
        bus.opcode_i = OPC_LOAD; bus.funct3_i = 3'b010; bus.funct7_i = '0;
        wb_at = -1; mr_cnt = 0; waits = 0; rs_wb = -1;
        for (int c = 0; c < 15 && wb_at < 0; c++) begin
            bus.mem_ready_i = !(bus.state_o == S_MEM_READ && waits < 3);
            if (!bus.mem_ready_i) waits++;
            @(negedge clk);
            if (bus.state_o == S_MEM_READ) mr_cnt += int'(bus.Mem_Read_o);
            if (bus.state_o == S_MEM_WB) begin
                wb_at = c;
                rs_wb = int'(bus.Result_Src_o);
            end
            @(posedge clk);
            #1;
        end
        chk_int(mr_cnt, 4, "lw_wait_mem_read_cycles");
        chk_int(wb_at, 7, "lw_wait_mem_wb_cycle");
        chk_int(rs_wb, 1, "lw_wait_result_src");

        // Illegal opcode: absorbing HALT, recovery by reset.
        reset_dut();
        run_instr(7'h7f, 3'b000, 7'h00, -1, 0, h);
        chk_int(int'(h), 1, "illegal_reaches_halt");
        fe = ph(S_HALT, "halt_hold"); fe.o.hlt = 1;
        for (int k = 0; k < 20; k++) begin
            bus.mem_ready_i = 1'($urandom); bus.zero_i = 1'($urandom);
            cyc(fe.o, "halt_hold");
        end
        reset_dut();
        bus.mem_ready_i = 1'b0;
        sq = build(OPC_R, 3'b000, 7'h00);
        fe = sq[0]; fe.o.pcw = 0; fe.o.irw = 0;
        cyc(fe.o, "fetch_after_halt_reset");

        // Reset while in MEM_WRITE with memory ready: no write, then FETCH.
        reset_dut();
        sq = build(OPC_STORE, 3'b010, 7'h00);
        bus.opcode_i = OPC_STORE; bus.funct3_i = 3'b010; bus.funct7_i = '0;
        bus.mem_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) cyc(sq[k].o, sq[k].nm);
        reset = 1'b0;
        cyc('0, "reset_in_mem_write");
        reset = 1'b1;
        cyc(sq[0].o, "fetch_after_sw_reset");
        reset_dut();

        // Random instruction stream against the trace model.
        for (int n = 0; n < 60; n++) begin
            int pick;
            logic [2:0] f3;
            pick = int'($urandom_range(0, 10));
            f3 = 3'b000;
            case (pick)
                0: run_instr(OPC_R, 3'b000, 7'h00, -1, -1, h);
                1: run_instr(OPC_R, 3'b000, 7'h20, -1, -1, h);
                2: run_instr(OPC_R, 3'b111, 7'h00, -1, -1, h);
                3: run_instr(OPC_R, 3'b110, 7'h00, -1, -1, h);
                4: begin
                    case ($urandom_range(0, 2))
                        0: f3 = 3'b000;
                        1: f3 = 3'b110;
                        default: f3 = 3'b111;
                    endcase
                    run_instr(OPC_I, f3, 7'($urandom), -1, -1, h);
                end
                5: run_instr(OPC_LOAD, 3'b010, 7'h00, -1, -1, h);
                6: run_instr(OPC_STORE, 3'b010, 7'h00, -1, -1, h);
                7: run_instr(OPC_BRANCH, 3'b000, 7'h00, -1, -1, h);
                8: run_instr(OPC_JAL, 3'($urandom), 7'($urandom), -1, -1, h);
                9: run_instr(OPC_LUI, 3'($urandom), 7'($urandom), -1, -1, h);
                default: run_instr(7'h0f, 3'b000, 7'h00, -1, -1, h);
            endcase
            if (h) reset_dut();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
